led_mode_scheduler: RTL

Sequences the bank of LED pattern drivers (steady, breathing, water-flow, and so on) and multiplexes one of them onto the board LEDs. A debounced push-button advances to the next mode. An optional dwell timer also advances modes automatically. Every mode change inserts a blanking gap and restarts the incoming driver from its reset state, so each pattern always begins at its first frame.

---
 rtl/led_mode_scheduler.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/led_mode_scheduler.sv
// LED pattern mode scheduler: debounced button advance, blanking gap, driver restart and output mux.
// Define LED_SCHED_AUTO_CYCLE_EN to add the dwell timer that auto-advances modes.
module led_mode_scheduler #(
  parameter int unsigned NUM_MODES       = 4,
  parameter int unsigned BLANK_CYCLES    = 100,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned DWELL_CYCLES    = 50_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   btn_raw,
  input  logic [8*NUM_MODES-1:0] mode_led_in,
  output logic [7:0]             led_out,
  output logic [2:0]             mode_sel,
  output logic [NUM_MODES-1:0]   drv_rst_n,
  output logic                   busy
);

  localparam int unsigned BlankW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam int unsigned DebW   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [BlankW-1:0] BlankLast = BlankW'(BLANK_CYCLES - 1);
  localparam logic [DebW-1:0]   DebLast   = DebW'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]        ModeLast  = 3'(NUM_MODES - 1);

  typedef enum logic [0:0] {StBlank, StRun} state_e;

  state_e                state_q, state_d;
  logic [2:0]            mode_q, mode_d;
  logic [BlankW-1:0]     blank_cnt_q, blank_cnt_d;
  logic [7:0]            led_q, led_d, led_sel;
  logic [NUM_MODES-1:0]  drv_q, drv_d;
  logic                  sync1_q, sync2_q;
  logic                  db_q, db_d, db_prev_q;
  logic [DebW-1:0]       deb_cnt_q, deb_cnt_d;
  logic                  press, expire, advance;

  // Counter only runs while the synchronized level disagrees with the debounced one.
  always_comb begin
    db_d      = db_q;
    deb_cnt_d = '0;
    if (sync2_q != db_q) begin
      if (deb_cnt_q == DebLast) begin
        db_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  assign press = db_q & ~db_prev_q;

`ifdef LED_SCHED_AUTO_CYCLE_EN
  localparam int unsigned DwellW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  logic [DwellW-1:0] dwell_q, dwell_d;

  assign expire = (state_q == StRun) && (dwell_q == DwellW'(DWELL_CYCLES - 1));

  always_comb begin
    dwell_d = '0;
    if ((state_q == StRun) && (state_d == StRun)) begin
      dwell_d = dwell_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_q <= '0;
    end else begin
      dwell_q <= dwell_d;
    end
  end
`else
  logic unused_dwell;
  assign unused_dwell = (DWELL_CYCLES != 0);
  assign expire       = 1'b0;
`endif

  assign advance = press | expire;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    blank_cnt_d = blank_cnt_q;
    unique case (state_q)
      StBlank: begin
        if (blank_cnt_q == BlankLast) begin
          state_d     = StRun;
          blank_cnt_d = '0;
        end else begin
          blank_cnt_d = blank_cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (advance) begin
          state_d     = StBlank;
          blank_cnt_d = '0;
          mode_d      = (mode_q == ModeLast) ? 3'd0 : mode_q + 3'd1;
        end
      end
      default: state_d = StBlank;
    endcase
  end

  always_comb begin
    led_sel = '0;
    drv_d   = '0;
    for (int unsigned k = 0; k < NUM_MODES; k++) begin
      if (mode_q == 3'(k)) led_sel = mode_led_in[8*k +: 8];
      drv_d[k] = (state_d == StRun) && (mode_d == 3'(k));
    end
    // Blank the output on the very cycle the mode change is taken.
    led_d = ((state_q == StRun) && (state_d == StRun)) ? led_sel : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StBlank;
      mode_q      <= '0;
      blank_cnt_q <= '0;
      led_q       <= '0;
      drv_q       <= '0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      db_q        <= 1'b0;
      db_prev_q   <= 1'b0;
      deb_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      blank_cnt_q <= blank_cnt_d;
      led_q       <= led_d;
      drv_q       <= drv_d;
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      db_q        <= db_d;
      db_prev_q   <= db_q;
      deb_cnt_q   <= deb_cnt_d;
    end
  end

  assign led_out   = led_q;
  assign mode_sel  = mode_q;
  assign drv_rst_n = drv_q;
  assign busy      = (state_q == StBlank);

endmodule
